add_reservation_station: RTL

Adder-side reservation station for the Tomasulo core. It receives up to two issued instructions per cycle from the instruction decode/issue unit and holds them until both operands are available. Waiting operands are captured from the common data bus (CDB), and ready entries are dispatched oldest-first through a valid/ready handshake to the adder. It drives `AR_Status` back to the issue unit so the issue unit can decide how many instructions to send.

---
 rtl/add_reservation_station.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/add_reservation_station.sv
// Adder-side reservation station: dual issue, CDB wakeup with same-cycle bypass,
// oldest-first dispatch through a registered valid/ready offer to the adder.
module add_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue1_valid,
  input  logic [7:0]        issue1_type,
  input  logic [TAG_W-1:0]  issue1_dest,
  input  logic              issue1_src1_rdy,
  input  logic [DATA_W-1:0] issue1_src1,
  input  logic              issue1_src2_rdy,
  input  logic [DATA_W-1:0] issue1_src2,
  input  logic              issue2_valid,
  input  logic [7:0]        issue2_type,
  input  logic [TAG_W-1:0]  issue2_dest,
  input  logic              issue2_src1_rdy,
  input  logic [DATA_W-1:0] issue2_src1,
  input  logic              issue2_src2_rdy,
  input  logic [DATA_W-1:0] issue2_src2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic [7:0]        exec_type,
  output logic [TAG_W-1:0]  exec_dest,
  output logic [DATA_W-1:0] exec_a,
  output logic [DATA_W-1:0] exec_b,
  output logic [3:0]        free_cnt,
  output logic              AR_Status,
  output logic              overflow_err
);

  logic [DEPTH-1:0]  ent_vld;
  logic [DEPTH-1:0]  ent_rdy1;
  logic [DEPTH-1:0]  ent_rdy2;
  logic [7:0]        ent_type [DEPTH];
  logic [TAG_W-1:0]  ent_dest [DEPTH];
  logic [DATA_W-1:0] ent_op1  [DEPTH];
  logic [DATA_W-1:0] ent_op2  [DEPTH];
  // older_than[i] has bit j set when entry j was allocated before entry i
  logic [DEPTH-1:0]  older_than [DEPTH];

  logic [DEPTH-1:0]  eligible;
  logic [DEPTH-1:0]  oldest;
  logic [DEPTH-1:0]  pick;
  logic [DEPTH-1:0]  release_m;
  logic [DEPTH-1:0]  avail;
  logic [DEPTH-1:0]  alloc1;
  logic [DEPTH-1:0]  alloc2;
  logic [DEPTH-1:0]  vld_next;
  logic [DEPTH-1:0]  survivors;
  logic              take;
  logic              ovf_now;
  logic [3:0]        free_next;
  logic [7:0]        pick_type;
  logic [TAG_W-1:0]  pick_dest;
  logic [DATA_W-1:0] pick_a;
  logic [DATA_W-1:0] pick_b;
  logic [DATA_W:0]   i1_op1;
  logic [DATA_W:0]   i1_op2;
  logic [DATA_W:0]   i2_op1;
  logic [DATA_W:0]   i2_op2;

  function automatic logic [DEPTH-1:0] lowest_one(input logic [DEPTH-1:0] m);
    return m & (~m + DEPTH'(1));
  endfunction

  function automatic logic [3:0] count_ones(input logic [DEPTH-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

  // Returns {rdy, value}; a pending tag that the CDB broadcasts this cycle is taken directly.
  function automatic logic [DATA_W:0] resolve_op(input logic rdy, input logic [DATA_W-1:0] src,
                                                 input logic bvld, input logic [TAG_W-1:0] btag,
                                                 input logic [DATA_W-1:0] bdata);
    if (!rdy && bvld && (src[TAG_W-1:0] == btag)) return {1'b1, bdata};
    return {rdy, src};
  endfunction

  always_comb begin
    i1_op1 = resolve_op(issue1_src1_rdy, issue1_src1, cdb_valid, cdb_tag, cdb_data);
    i1_op2 = resolve_op(issue1_src2_rdy, issue1_src2, cdb_valid, cdb_tag, cdb_data);
    i2_op1 = resolve_op(issue2_src1_rdy, issue2_src1, cdb_valid, cdb_tag, cdb_data);
    i2_op2 = resolve_op(issue2_src2_rdy, issue2_src2, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    eligible = ent_vld & ent_rdy1 & ent_rdy2;
    oldest   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && ((older_than[i] & eligible) == '0)) oldest[i] = 1'b1;
    end
    pick      = lowest_one(oldest);
    take      = (pick != '0) && (!exec_valid || exec_ready);
    release_m = take ? pick : '0;
    survivors = ent_vld & ~release_m;
    avail     = ~survivors;
    alloc1    = issue1_valid ? lowest_one(avail) : '0;
    alloc2    = issue2_valid ? lowest_one(avail & ~alloc1) : '0;
    ovf_now   = (issue1_valid && (alloc1 == '0)) || (issue2_valid && (alloc2 == '0));
    vld_next  = survivors | alloc1 | alloc2;
    free_next = 4'(DEPTH) - count_ones(vld_next);
  end

  always_comb begin
    pick_type = '0;
    pick_dest = '0;
    pick_a    = '0;
    pick_b    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick[i]) begin
        pick_type = ent_type[i];
        pick_dest = ent_dest[i];
        pick_a    = ent_op1[i];
        pick_b    = ent_op2[i];
      end
    end
  end

  // Entry payload, operand wakeup and age tracking; only meaningful under ent_vld
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc1[i]) begin
        ent_type[i]   <= issue1_type;
        ent_dest[i]   <= issue1_dest;
        {ent_rdy1[i], ent_op1[i]} <= i1_op1;
        {ent_rdy2[i], ent_op2[i]} <= i1_op2;
        older_than[i] <= survivors;
      end else if (alloc2[i]) begin
        ent_type[i]   <= issue2_type;
        ent_dest[i]   <= issue2_dest;
        {ent_rdy1[i], ent_op1[i]} <= i2_op1;
        {ent_rdy2[i], ent_op2[i]} <= i2_op2;
        older_than[i] <= survivors | alloc1;
      end else begin
        older_than[i] <= older_than[i] & ~(alloc1 | alloc2);
        if (ent_vld[i] && cdb_valid && !ent_rdy1[i] && (ent_op1[i][TAG_W-1:0] == cdb_tag)) begin
          ent_rdy1[i] <= 1'b1;
          ent_op1[i]  <= cdb_data;
        end
        if (ent_vld[i] && cdb_valid && !ent_rdy2[i] && (ent_op2[i][TAG_W-1:0] == cdb_tag)) begin
          ent_rdy2[i] <= 1'b1;
          ent_op2[i]  <= cdb_data;
        end
      end
    end
  end

  // Occupancy, dispatch offer register and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld      <= '0;
      exec_valid   <= 1'b0;
      exec_type    <= '0;
      exec_dest    <= '0;
      exec_a       <= '0;
      exec_b       <= '0;
      free_cnt     <= 4'(DEPTH);
      AR_Status    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      ent_vld <= vld_next;
      if (take) begin
        exec_valid <= 1'b1;
        exec_type  <= pick_type;
        exec_dest  <= pick_dest;
        exec_a     <= pick_a;
        exec_b     <= pick_b;
      end else if (exec_ready) begin
        exec_valid <= 1'b0;
      end
      free_cnt  <= free_next;
      AR_Status <= (free_next < 4'd2);
      if (ovf_now) overflow_err <= 1'b1;
    end
  end

endmodule
